// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks an active-low column strobe, debounces row presses and
// releases, and hands out one key code per physical press on a valid/ready handshake.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       key_held
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_EMIT,
    S_RELEASE
  } state_e;

  state_e           state_q;
  logic [3:0]       rs1_q;
  logic [3:0]       rs_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q;
  logic [1:0]       row_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       col_out_q;
  logic             valid_q;
  logic [3:0]       code_q;
  logic             held_q;

  logic             sample_c;
  logic             single_c;
  logic [1:0]       row_idx_c;
  logic [2:0]       zeros_c;
  logic [1:0]       col_d;
  logic [3:0]       col_out_d;
  logic [CNT_W-1:0] cnt_d;

  // Keymap indexed by [row][col].
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // A sample counts as a press only when exactly one synchronised row is low.
  always_comb begin
    zeros_c   = '0;
    row_idx_c = '0;
    for (int i = 0; i < 4; i++) begin
      if (!rs_q[i]) begin
        zeros_c   = zeros_c + 3'd1;
        row_idx_c = 2'(i);
      end
    end
    single_c  = (zeros_c == 3'd1);
    sample_c  = (div_q == DIV_LAST);
    col_d     = col_q + 2'd1;
    col_out_d = ~(4'b0001 << col_d);
    cnt_d     = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_SCAN;
      rs1_q     <= 4'b1111;
      rs_q      <= 4'b1111;
      div_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      col_out_q <= 4'b1110;
      valid_q   <= 1'b0;
      code_q    <= '0;
      held_q    <= 1'b0;
    end else begin
      rs1_q <= row_in;
      rs_q  <= rs1_q;
      div_q <= sample_c ? '0 : div_q + DIV_W'(1);
      case (state_q)
        S_SCAN: begin
          if (sample_c) begin
            if (single_c) begin
              row_q   <= row_idx_c;
              cnt_q   <= '0;
              state_q <= S_DEBOUNCE;
            end else begin
              col_q     <= col_d;
              col_out_q <= col_out_d;
            end
          end
        end
        S_DEBOUNCE: begin
          if (sample_c) begin
            if (single_c && (row_idx_c == row_q)) begin
              if (cnt_d == CNT_DONE) begin
                code_q  <= keymap(row_q, col_q);
                valid_q <= 1'b1;
                state_q <= S_EMIT;
              end else begin
                cnt_q <= cnt_d;
              end
            end else begin
              state_q   <= S_SCAN;
              col_q     <= col_d;
              col_out_q <= col_out_d;
            end
          end
        end
        S_EMIT: begin
          if (valid_q && key_ready) begin
            valid_q <= 1'b0;
            held_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_RELEASE;
          end
        end
        default: begin
          // Any row activity restarts the release count.
          if (sample_c) begin
            if (rs_q == 4'b1111) begin
              if (cnt_d == CNT_DONE) begin
                held_q    <= 1'b0;
                state_q   <= S_SCAN;
                col_q     <= col_d;
                col_out_q <= col_out_d;
              end else begin
                cnt_q <= cnt_d;
              end
            end else begin
              cnt_q <= '0;
            end
          end
        end
      endcase
    end
  end

  assign col_out   = col_out_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a modelled 4x4 keypad matrix, directed corner cases,
// a per-key vector table and randomized presses checked against a press-to-code model.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready = 1'b0;
  logic        key_held;
  logic [15:0] keys = '0;

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0] acc_q[$];
  int         exp_q[$];

  typedef struct {
    int         r;
    int         c;
    logic [3:0] code;
  } vec_t;
  vec_t vecs[16];

  always #5 clock = ~clock;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clock    (clock),
    .reset    (reset),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .key_held (key_held)
  );

  // Row r is pulled low when its key in the currently strobed column is held.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // Record every handshake that the next rising edge will complete.
  always @(negedge clock)
    if (!reset && key_valid && key_ready) acc_q.push_back(key_code);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic press(input int r, input int c);
    keys[r*4+c] = 1'b1;
  endtask

  // which: 0 = key_valid, 1 = key_held
  task automatic wait_sig(input int which, input logic val, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (((which == 0) ? key_valid : key_held) == val) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  function automatic int first_code();
    return (acc_q.size() > 0) ? int'(acc_q[0]) : -1;
  endfunction

  initial begin
    bit         ok;
    bit         seen;
    logic [3:0] exp_col;

    vecs = '{'{0, 0, 4'h1}, '{0, 1, 4'h2}, '{0, 2, 4'h3}, '{0, 3, 4'hA},
             '{1, 0, 4'h4}, '{1, 1, 4'h5}, '{1, 2, 4'h6}, '{1, 3, 4'hB},
             '{2, 0, 4'h7}, '{2, 1, 4'h8}, '{2, 2, 4'h9}, '{2, 3, 4'hC},
             '{3, 0, 4'h0}, '{3, 1, 4'hF}, '{3, 2, 4'hE}, '{3, 3, 4'hD}};

    // Reset values
    ticks(3);
    check("rst_col", col_out, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_held", key_held, 0);
    reset = 1'b0;

    // Idle scanning: one column step every SCAN_DIV clocks
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (key_valid) seen = 1'b1;
      if (i % 4 == 0) begin
        exp_col = ~(4'b0001 << ((i / 4) % 4));
        check("idle_col", col_out, exp_col);
      end
    end
    check("idle_no_valid", seen, 0);

    // Enter key with ready high: one code, held until debounced release
    acc_q.delete();
    key_ready = 1'b1;
    press(3, 2);
    wait_sig(1, 1'b1, 100, ok);
    check("enter_held_rise", ok, 1);
    ticks(40);
    keys = '0;
    ticks(3);
    check("enter_held_after_release", key_held, 1);
    wait_sig(1, 1'b0, 60, ok);
    check("enter_held_fall", ok, 1);
    ticks(40);
    check("enter_count", acc_q.size(), 1);
    check("enter_code", first_code(), 14);

    // Backpressure: code stays stable, EMIT waits even after release
    acc_q.delete();
    key_ready = 1'b0;
    press(0, 0);
    wait_sig(0, 1'b1, 100, ok);
    check("bp_valid_rise", ok, 1);
    seen = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!(key_valid && key_code == 4'h1)) seen = 1'b0;
    end
    check("bp_stable", seen, 1);
    keys = '0;
    ticks(20);
    check("bp_valid_after_release", key_valid, 1);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("bp_valid_cleared", key_valid, 0);
    check("bp_held_set", key_held, 1);
    wait_sig(1, 1'b0, 30, ok);
    check("bp_release_done", ok, 1);
    check("bp_count", acc_q.size(), 1);
    check("bp_code", first_code(), 1);

    // Bounce: one qualifying sample, then release
    acc_q.delete();
    key_ready = 1'b1;
    for (int i = 0; i < 20 && col_out == 4'b1101; i++) tick();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (col_out == 4'b1101) begin
        ok = 1'b1;
        break;
      end
    end
    check("bounce_col1_found", ok, 1);
    press(1, 1);
    ticks(4);
    check("bounce_col_held", col_out, 4'b1101);
    keys = '0;
    ticks(4);
    check("bounce_resume_col2", col_out, 4'b1011);
    ticks(30);
    check("bounce_no_code", acc_q.size(), 0);

    // Two rows in one column are ignored until one lets go
    acc_q.delete();
    press(0, 1);
    press(2, 1);
    ticks(60);
    check("multi_no_code", acc_q.size(), 0);
    keys[2*4+1] = 1'b0;
    wait_sig(1, 1'b1, 100, ok);
    check("multi_held_rise", ok, 1);
    keys = '0;
    wait_sig(1, 1'b0, 60, ok);
    check("multi_held_fall", ok, 1);
    ticks(20);
    check("multi_count", acc_q.size(), 1);
    check("multi_code", first_code(), 2);

    // Reset with a pending code discards it
    acc_q.delete();
    key_ready = 1'b0;
    press(3, 3);
    wait_sig(0, 1'b1, 100, ok);
    check("rstemit_valid", ok, 1);
    check("rstemit_code", key_code, 13);
    reset = 1'b1;
    tick();
    check("rstemit_valid_clr", key_valid, 0);
    check("rstemit_held_clr", key_held, 0);
    check("rstemit_col", col_out, 4'b1110);
    keys = '0;
    tick();
    reset = 1'b0;
    key_ready = 1'b1;
    ticks(40);
    check("rstemit_never_accepted", acc_q.size(), 0);

    // Every key through the table
    for (int v = 0; v < 16; v++) begin
      key_ready = 1'b0;
      press(vecs[v].r, vecs[v].c);
      wait_sig(0, 1'b1, 100, ok);
      check("table_code", ok ? int'(key_code) : -1, vecs[v].code);
      key_ready = 1'b1;
      tick();
      key_ready = 1'b0;
      keys = '0;
      wait_sig(1, 1'b0, 60, ok);
      check("table_release", ok, 1);
    end

    // Random presses with random backpressure: one code per press, in order
    acc_q.delete();
    exp_q.delete();
    for (int n = 0; n < 12; n++) begin
      int r, c, hold;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      hold = $urandom_range(40, 100);
      press(r, c);
      exp_q.push_back(vecs[r*4+c].code);
      for (int i = 0; i < hold; i++) begin
        key_ready = 1'($urandom_range(0, 1));
        tick();
      end
      keys = '0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        key_ready = 1'($urandom_range(0, 1));
        tick();
        if (!key_held && !key_valid) begin
          ok = 1'b1;
          break;
        end
      end
      check("rand_idle", ok, 1);
      ticks(2);
    end
    key_ready = 1'b0;
    check("rand_count", acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check("rand_code", (i < acc_q.size()) ? int'(acc_q[i]) : -1, exp_q[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
